// File: rtl/matrix_result_streamer_pkg.sv
// Shared definitions for the matrix result streamer: dimensions, index type,
// FSM state encoding and the flat element selector.
package la_pkg;
  localparam int unsigned LA_N  = 5;
  localparam int unsigned LA_DW = 64;

  typedef logic [2:0] idx_t;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  function automatic int unsigned elem_sel(idx_t r, idx_t c);
    return r * LA_N + c;
  endfunction
endpackage

// File: rtl/matrix_result_streamer_index.sv
// Row/column walker for one streamed matrix; order is latched on restart so a
// matrix keeps its traversal even if the next capture requests the other order.
module matrix_index_counter
  import la_pkg::*;
#(
  parameter int unsigned N = LA_N
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic advance,
  input  logic col_major,
  output idx_t row,
  output idx_t col,
  output logic last_line,
  output logic last
);
  localparam idx_t LAST = idx_t'(N - 1);

  logic mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      mode_q <= 1'b0;
    end else if (restart) begin
      row    <= '0;
      col    <= '0;
      mode_q <= col_major;
    end else if (advance) begin
      if (!mode_q) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        if (row == LAST) begin
          row <= '0;
          col <= (col == LAST) ? '0 : col + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

  assign last_line = mode_q ? (row == LAST) : (col == LAST);
  assign last      = (row == LAST) && (col == LAST);
endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a full N x N result matrix in one handshake and streams it one
// element per valid/ready beat in row- or column-major order.
module matrix_result_streamer
  import la_pkg::*;
#(
  parameter int unsigned N    = LA_N,
  parameter int unsigned DW   = LA_DW,
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_col_major,
  input  logic [N*N*DW-1:0]   m_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output idx_t                out_row,
  output idx_t                out_col,
  output logic                out_last_line,
  output logic                out_last,
  output logic [CNTW-1:0]     mat_count
);
  // state    | meaning
  // S_IDLE   | no matrix held, in_ready high
  // S_STREAM | emitting captured matrix, one element per accepted beat
  state_t            state_q, state_d;
  logic [N*N*DW-1:0] cap_q;
  logic              capture;
  logic              accept;
  int unsigned       sel;

  assign out_valid = (state_q == S_STREAM);
  assign accept    = out_valid && out_ready;
  // Reopening on the last accepted beat is what gives zero-bubble back-to-back.
  assign in_ready  = (state_q == S_IDLE) || (out_valid && out_last && out_ready);
  assign capture   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (capture) state_d = S_STREAM;
      S_STREAM: if (accept && out_last && !capture) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cap_q <= '0;
    else if (capture) cap_q <= m_flat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     mat_count <= '0;
    else if (accept && out_last) mat_count <= mat_count + 1'b1;
  end

  matrix_index_counter #(.N(N)) u_index (
    .clk       (clk),
    .rst       (rst),
    .restart   (capture),
    .advance   (accept),
    .col_major (in_col_major),
    .row       (out_row),
    .col       (out_col),
    .last_line (out_last_line),
    .last      (out_last)
  );

  assign sel      = elem_sel(out_row, out_col);
  assign out_data = cap_q[sel*DW +: DW];
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed + randomized bench for matrix_result_streamer against a queue-based
// model of expected beats; a second instance with CNTW=2 exercises counter wrap.
module tb_matrix_result_streamer;
  localparam int N  = 5;
  localparam int DW = 64;
  localparam int FW = N * N * DW;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        ll;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_col_major, out_ready;
  logic [FW-1:0] m_flat;

  logic          in_ready, out_valid, out_last_line, out_last;
  logic [DW-1:0] out_data;
  logic [2:0]    out_row, out_col;
  logic [15:0]   mat_count;

  logic          in_ready2, out_valid2, out_last_line2, out_last2;
  logic [DW-1:0] out_data2;
  logic [2:0]    out_row2, out_col2;
  logic [1:0]    mat_count2;

  beat_t q[$];
  int    tests = 0, fails = 0;
  int    cnt = 0, beats = 0, cyc = 0;
  int    rdy_mode = 0;
  bit    captured;

  always #5 clk = ~clk;

  matrix_result_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_col_major(in_col_major), .m_flat(m_flat), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last_line(out_last_line), .out_last(out_last),
    .mat_count(mat_count)
  );

  matrix_result_streamer #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_col_major(in_col_major), .m_flat(m_flat), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_row(out_row2),
    .out_col(out_col2), .out_last_line(out_last_line2), .out_last(out_last2),
    .mat_count(mat_count2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_seq(input int base);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < N * N; k++) f[k*DW +: DW] = 64'(k + base);
    return f;
  endfunction

  function automatic logic [FW-1:0] mk_rand();
    logic [FW-1:0] f;
    for (int k = 0; k < N * N; k++) f[k*DW +: DW] = {$urandom, $urandom};
    return f;
  endfunction

  // Expected beat list of one matrix, built from the traversal rules directly.
  task automatic push_matrix(input logic [FW-1:0] f, input logic cm);
    beat_t b;
    for (int o = 0; o < N; o++)
      for (int i = 0; i < N; i++) begin
        int r, c;
        r = cm ? i : o;
        c = cm ? o : i;
        b.data = f[(r*N + c)*DW +: DW];
        b.row  = 3'(r);
        b.col  = 3'(c);
        b.ll   = (i == N - 1);
        b.last = (o == N - 1) && (i == N - 1);
        q.push_back(b);
      end
  endtask

  task automatic step();
    logic exp_rdy;
    @(negedge clk);
    chk("mat_count", 64'(mat_count), 64'(cnt % 65536));
    chk("mat_count_w2", 64'(mat_count2), 64'(cnt % 4));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_valid_w2", 64'(out_valid2), 64'(q.size() != 0));
    exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("in_ready_w2", 64'(in_ready2), 64'(exp_rdy));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_data_w2", out_data2, q[0].data);
      chk("out_row", 64'(out_row), 64'(q[0].row));
      chk("out_col", 64'(out_col), 64'(q[0].col));
      chk("out_row_w2", 64'(out_row2), 64'(q[0].row));
      chk("out_col_w2", 64'(out_col2), 64'(q[0].col));
      chk("out_last_line", 64'(out_last_line), 64'(q[0].ll));
      chk("out_last", 64'(out_last), 64'(q[0].last));
      chk("out_last_line_w2", 64'(out_last_line2), 64'(q[0].ll));
      chk("out_last_w2", 64'(out_last2), 64'(q[0].last));
      if (out_ready) begin
        if (q[0].last) cnt++;
        beats++;
        void'(q.pop_front());
      end
    end
    if (in_valid && exp_rdy) begin
      push_matrix(m_flat, in_col_major);
      captured = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic send_matrix(input logic [FW-1:0] f, input logic cm);
    in_valid     = 1'b1;
    m_flat       = f;
    in_col_major = cm;
    captured     = 1'b0;
    for (int i = 0; i < 400 && !captured; i++) step();
    chk("capture_timeout", 64'(captured), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) step();
    chk("drain_timeout", 64'(q.size()), 64'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_col_major = 1'b0; out_ready = 1'b1; m_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_row", 64'(out_row), 64'd0);
    chk("rst_out_col", 64'(out_col), 64'd0);
    chk("rst_mat_count", 64'(mat_count), 64'd0);
    rst = 1'b0;
    step();

    // row-major then column-major, continuous ready
    send_matrix(mk_seq(1), 1'b0);
    drain();
    chk("count_after_rm", 64'(mat_count), 64'd1);
    send_matrix(mk_seq(1), 1'b1);
    drain();

    // backpressure 1,0,0,1
    rdy_mode = 1;
    send_matrix(mk_seq(1), 1'b0);
    drain();
    send_matrix(mk_seq(1), 1'b1);
    drain();
    rdy_mode = 0;

    // back-to-back A then B with in_valid held
    send_matrix(mk_seq(1), 1'b0);
    send_matrix(mk_seq(101), 1'b0);
    drain();

    // reset after beat 12
    beats = 0;
    send_matrix(mk_seq(1), 1'b0);
    for (int i = 0; i < 100 && beats < 12; i++) step();
    chk("beats_before_reset", 64'(beats), 64'd12);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_mat_count", 64'(mat_count), 64'd0);
    chk("midrst_mat_count_w2", 64'(mat_count2), 64'd0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_matrix(mk_seq(1), 1'b0);
    step();
    chk("restart_first_data", out_data, 64'd2);
    drain();

    // counter wrap on the CNTW=2 instance
    for (int k = 0; k < 3; k++) begin
      send_matrix(mk_seq(10 * k), k[0]);
      drain();
      chk("wrap_seq", 64'(mat_count2), 64'((cnt) % 4));
    end

    // randomized data, order, ready and back-to-back pairs
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      send_matrix(mk_rand(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) send_matrix(mk_rand(), 1'($urandom_range(0, 1)));
      drain();
    end
    rdy_mode = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
